// File: rtl/msrv_32_wb_stage_unit.sv
// rtl/msrv_32_wb_stage_unit.sv - registered writeback stage with late-load wait, x0 suppression and retire counter
module msrv_32_wb_stage_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 6,
    parameter int SEL_W    = 3,
    parameter int LOAD_SEL = 1,
    parameter int CNT_W    = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [SEL_W-1:0]        wb_mux_sel_in,
    input  logic [NUM_SRC*XLEN-1:0] src_data_in,
    input  logic [4:0]              rd_addr_in,
    input  logic                    rf_wr_en_in,
    input  logic                    lu_valid_in,
    input  logic                    stall_in,
    input  logic                    flush_in,
    input  logic [XLEN-1:0]         rs2_in,
    input  logic [XLEN-1:0]         imm_in,
    input  logic                    alu_src_in,
    output logic [XLEN-1:0]         alu_2nd_src_out,
    output logic [XLEN-1:0]         wb_data_out,
    output logic [4:0]              rd_addr_out,
    output logic                    rf_wr_en_out,
    output logic                    wb_valid_out,
    output logic [CNT_W-1:0]        instret_out
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] ret_data;
    logic [4:0]      ret_rd;
    logic            ret_wr;
    logic [4:0]      pend_rd;
    logic            pend_wr;
    logic            accept, is_load, retire, capture;

    assign alu_2nd_src_out = alu_src_in ? rs2_in : imm_in;
    assign ready_out       = (state == IDLE) && !stall_in;
    assign accept          = valid_in && ready_out && !flush_in;
    assign is_load         = (wb_mux_sel_in == SEL_W'(LOAD_SEL));

    // Out-of-range selects fall back to source 0.
    always_comb begin
        sel_data = src_data_in[XLEN-1:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (wb_mux_sel_in == SEL_W'(k)) sel_data = src_data_in[k*XLEN +: XLEN];
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        capture    = 1'b0;
        ret_data   = sel_data;
        ret_rd     = rd_addr_in;
        ret_wr     = rf_wr_en_in;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_load && !lu_valid_in) begin
                        capture    = 1'b1;
                        state_next = WAIT_LOAD;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                ret_data = src_data_in[LOAD_SEL*XLEN +: XLEN];
                ret_rd   = pend_rd;
                ret_wr   = pend_wr;
                // Flush beats a same-cycle load completion.
                if (flush_in) begin
                    state_next = IDLE;
                end else if (lu_valid_in) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            pend_rd      <= '0;
            pend_wr      <= 1'b0;
            wb_data_out  <= '0;
            rd_addr_out  <= '0;
            rf_wr_en_out <= 1'b0;
            wb_valid_out <= 1'b0;
            instret_out  <= '0;
        end else begin
            state        <= state_next;
            wb_valid_out <= retire;
            rf_wr_en_out <= retire && ret_wr && (ret_rd != 5'd0);
            if (capture) begin
                pend_rd <= rd_addr_in;
                pend_wr <= rf_wr_en_in;
            end
            if (retire) begin
                wb_data_out <= ret_data;
                rd_addr_out <= ret_rd;
                instret_out <= instret_out + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_msrv_32_wb_stage_unit.sv
// tb/tb_msrv_32_wb_stage_unit.sv - randomized and directed bench for msrv_32_wb_stage_unit
module tb_msrv_32_wb_stage_unit;
    logic        clk = 1'b0;
    logic        rst, valid, lu_valid, stall, flush, wr, alu_src;
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic [31:0] srcs [6];
    logic [31:0] rs2, imm;
    logic [191:0] src_flat;
    logic        ready, wr_out, wb_valid;
    logic [31:0] alu2, wb_data;
    logic [4:0]  rd_out;
    logic [63:0] instret;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural view of the stage
    bit          m_wait;
    logic [4:0]  m_prd;
    bit          m_pwr;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    bit          m_wr, m_valid;
    logic [63:0] m_cnt;

    always #5 clk = ~clk;

    assign src_flat = {srcs[5], srcs[4], srcs[3], srcs[2], srcs[1], srcs[0]};

    msrv_32_wb_stage_unit dut (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready),
        .wb_mux_sel_in(sel), .src_data_in(src_flat), .rd_addr_in(rd), .rf_wr_en_in(wr),
        .lu_valid_in(lu_valid), .stall_in(stall), .flush_in(flush),
        .rs2_in(rs2), .imm_in(imm), .alu_src_in(alu_src), .alu_2nd_src_out(alu2),
        .wb_data_out(wb_data), .rd_addr_out(rd_out), .rf_wr_en_out(wr_out),
        .wb_valid_out(wb_valid), .instret_out(instret)
    );

    task automatic model_edge();
        bit          ret = 0;
        logic [31:0] d = '0;
        logic [4:0]  r = '0;
        bit          w = 0;
        int          s;
        if (rst) begin
            m_wait = 0; m_prd = '0; m_pwr = 0;
            m_data = '0; m_rd = '0; m_wr = 0; m_valid = 0; m_cnt = '0;
            return;
        end
        if (m_wait) begin
            if (flush) m_wait = 0;
            else if (lu_valid) begin
                ret = 1; d = srcs[1]; r = m_prd; w = m_pwr; m_wait = 0;
            end
        end else if (valid && !stall && !flush) begin
            s = (int'(sel) >= 6) ? 0 : int'(sel);
            if (s == 1 && !lu_valid) begin
                m_wait = 1; m_prd = rd; m_pwr = wr;
            end else begin
                ret = 1; d = srcs[s]; r = rd; w = wr;
            end
        end
        m_valid = ret;
        m_wr    = ret && w && (r != 0);
        if (ret) begin
            m_data = d; m_rd = r; m_cnt = m_cnt + 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; lu_valid = 0; stall = 0; flush = 0; wr = 0; sel = '0; rd = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        alu_src = 0; rs2 = '0; imm = '0;
        for (int k = 0; k < 6; k++) srcs[k] = '0;
        step(); step();
        rst = 0;
        vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h exp 0", wb_data); end
        vectors++; if (rd_out !== 5'h0) begin miscompares++; $display("FAIL reset_rd got %h exp 0", rd_out); end
        vectors++; if (wr_out !== 1'b0) begin miscompares++; $display("FAIL reset_wr got %b exp 0", wr_out); end
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", wb_valid); end
        vectors++; if (instret !== 64'h0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", instret); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", ready); end
    endtask

    task automatic test_basic();
        valid = 1; sel = 3'd0; srcs[0] = 32'h0000_1234; rd = 5'd5; wr = 1;
        step();
        idle_inputs();
        vectors++; if (wb_data !== 32'h1234) begin miscompares++; $display("FAIL basic_data got %h exp 1234", wb_data); end
        vectors++; if (rd_out !== 5'd5) begin miscompares++; $display("FAIL basic_rd got %0d exp 5", rd_out); end
        vectors++; if (wr_out !== 1'b1) begin miscompares++; $display("FAIL basic_wr got %b exp 1", wr_out); end
        vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b exp 1", wb_valid); end
        vectors++; if (instret !== 64'd1) begin miscompares++; $display("FAIL basic_cnt got %0d exp 1", instret); end
        step();
        vectors++; if (wb_valid !== 1'b0 || wr_out !== 1'b0) begin miscompares++; $display("FAIL basic_pulse got v=%b w=%b exp 0 0", wb_valid, wr_out); end
        vectors++; if (wb_data !== 32'h1234) begin miscompares++; $display("FAIL basic_hold got %h exp 1234", wb_data); end
    endtask

    task automatic test_load_wait();
        logic [63:0] c0 = m_cnt;
        valid = 1; sel = 3'd1; lu_valid = 0; rd = 5'd7; wr = 1; srcs[1] = 32'h1111_1111;
        step();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_wait got %b exp 0", ready); end
            vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL load_early_pulse got %b exp 0", wb_valid); end
            step();
        end
        srcs[1] = 32'hDEAD_BEEF; lu_valid = 1;
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_lu got %b exp 0", ready); end
        step();
        lu_valid = 0;
        vectors++; if (wb_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_data got %h exp deadbeef", wb_data); end
        vectors++; if (rd_out !== 5'd7 || wr_out !== 1'b1 || wb_valid !== 1'b1) begin miscompares++; $display("FAIL load_ctl got rd=%0d w=%b v=%b exp 7 1 1", rd_out, wr_out, wb_valid); end
        vectors++; if (instret !== c0 + 64'd1) begin miscompares++; $display("FAIL load_cnt got %0d exp %0d", instret, c0 + 64'd1); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL load_ready_after got %b exp 1", ready); end
        step();
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL load_single_pulse got %b exp 0", wb_valid); end
    endtask

    task automatic test_x0();
        valid = 1; sel = 3'd2; srcs[2] = 32'h7; rd = 5'd0; wr = 1;
        step();
        idle_inputs();
        vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL x0_valid got %b exp 1", wb_valid); end
        vectors++; if (wr_out !== 1'b0) begin miscompares++; $display("FAIL x0_wr got %b exp 0", wr_out); end
        vectors++; if (wb_data !== 32'h7) begin miscompares++; $display("FAIL x0_data got %h exp 7", wb_data); end
    endtask

    task automatic test_flush_wait();
        logic [63:0] c0 = m_cnt;
        valid = 1; sel = 3'd1; lu_valid = 0; rd = 5'd3; wr = 1;
        step();
        idle_inputs();
        flush = 1; lu_valid = 1; srcs[1] = 32'hBAD0_BAD0;
        step();
        idle_inputs();
        vectors++; if (wb_valid !== 1'b0 || wr_out !== 1'b0) begin miscompares++; $display("FAIL flush_pulse got v=%b w=%b exp 0 0", wb_valid, wr_out); end
        vectors++; if (instret !== c0) begin miscompares++; $display("FAIL flush_cnt got %0d exp %0d", instret, c0); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b exp 1", ready); end
        valid = 1; sel = 3'd3; srcs[3] = 32'h0BAD_F00D; rd = 5'd9; wr = 1;
        step();
        idle_inputs();
        vectors++; if (wb_data !== 32'h0BAD_F00D || rd_out !== 5'd9 || wb_valid !== 1'b1) begin miscompares++; $display("FAIL flush_next got d=%h rd=%0d v=%b exp 0badf00d 9 1", wb_data, rd_out, wb_valid); end
        // stall must not hold back a waiting load
        valid = 1; sel = 3'd1; rd = 5'd4; wr = 1;
        step();
        idle_inputs();
        stall = 1; lu_valid = 1; srcs[1] = 32'h5555_AAAA;
        step();
        idle_inputs();
        vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'h5555_AAAA) begin miscompares++; $display("FAIL stall_load got v=%b d=%h exp 1 5555aaaa", wb_valid, wb_data); end
    endtask

    task automatic test_sel_oob();
        srcs[0] = 32'h0000_CAFE;
        for (int s = 6; s < 8; s++) begin
            valid = 1; sel = 3'(s); rd = 5'd2; wr = 1; srcs[5] = 32'hFFFF_0000 + 32'(s);
            step();
            idle_inputs();
            vectors++; if (wb_data !== 32'h0000_CAFE) begin miscompares++; $display("FAIL sel_oob_%0d got %h exp cafe", s, wb_data); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] c0 = m_cnt;
        for (int i = 0; i < 4; i++) begin
            valid = 1; sel = 3'd4; srcs[4] = 32'hA000 + 32'(i); rd = 5'(10 + i); wr = 1;
            step();
            vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hA000 + 32'(i)) begin miscompares++; $display("FAIL b2b_%0d got v=%b d=%h exp 1 %h", i, wb_valid, wb_data, 32'hA000 + 32'(i)); end
        end
        idle_inputs();
        vectors++; if (instret !== c0 + 64'd4) begin miscompares++; $display("FAIL b2b_cnt got %0d exp %0d", instret, c0 + 64'd4); end
    endtask

    task automatic test_stall();
        logic [31:0] held = m_data;
        stall = 1; valid = 1; sel = 3'd0; srcs[0] = 32'h1357_9BDF; rd = 5'd6; wr = 1;
        #1;
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready got %b exp 0", ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (wb_valid !== 1'b0 || wb_data !== held) begin miscompares++; $display("FAIL stall_hold got v=%b d=%h exp 0 %h", wb_valid, wb_data, held); end
        end
        idle_inputs();
    endtask

    task automatic test_alu_src();
        rs2 = 32'hA; imm = 32'hB; alu_src = 1;
        #1;
        vectors++; if (alu2 !== 32'hA) begin miscompares++; $display("FAIL alu_rs2 got %h exp a", alu2); end
        alu_src = 0;
        #1;
        vectors++; if (alu2 !== 32'hB) begin miscompares++; $display("FAIL alu_imm got %h exp b", alu2); end
    endtask

    task automatic test_reset_mid_wait();
        valid = 1; sel = 3'd1; rd = 5'd8; wr = 1;
        step();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        vectors++; if (wb_data !== 32'h0 || rd_out !== 5'h0 || wr_out !== 1'b0 || wb_valid !== 1'b0 || instret !== 64'h0) begin miscompares++; $display("FAIL rst_wait got d=%h rd=%0d w=%b v=%b c=%0d exp all 0", wb_data, rd_out, wr_out, wb_valid, instret); end
        lu_valid = 1;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_wait_ready got %b exp 1", ready); end
        step();
        lu_valid = 0;
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_discard got %b exp 0", wb_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            valid    = ($urandom_range(0, 3) != 0);
            sel      = 3'($urandom_range(0, 7));
            lu_valid = ($urandom_range(0, 2) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            wr       = $urandom_range(0, 1);
            rd       = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            alu_src  = $urandom_range(0, 1);
            rs2      = $urandom;
            imm      = $urandom;
            for (int k = 0; k < 6; k++) srcs[k] = $urandom;
            #1;
            vectors++; if (ready !== (!m_wait && !stall)) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, ready, !m_wait && !stall); end
            vectors++; if (alu2 !== (alu_src ? rs2 : imm)) begin miscompares++; $display("FAIL rnd_alu[%0d] got %h exp %h", i, alu2, alu_src ? rs2 : imm); end
            step();
            vectors++; if (wb_valid !== m_valid || wr_out !== m_wr) begin miscompares++; $display("FAIL rnd_pulse[%0d] got v=%b w=%b exp %b %b", i, wb_valid, wr_out, m_valid, m_wr); end
            vectors++; if (wb_data !== m_data || rd_out !== m_rd) begin miscompares++; $display("FAIL rnd_data[%0d] got d=%h rd=%0d exp %h %0d", i, wb_data, rd_out, m_data, m_rd); end
            vectors++; if (instret !== m_cnt) begin miscompares++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, instret, m_cnt); end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_wait();
        test_x0();
        test_flush_wait();
        test_sel_oob();
        test_back_to_back();
        test_stall();
        test_alu_src();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/msrv_32_wb_stage_unit.md
Name: msrv_32_wb_stage_unit

Overview:
Registered, parametrised writeback stage for the MSRV32 core. It generalises the combinational writeback select into NUM_SRC flattened XLEN-bit sources and a pipeline register with valid, stall and flush. It adds a wait state for late load data, an x0 write suppression and a retired-instruction counter. It sits between the execute/memory stage and the integer register file, and also provides the ALU second-operand select.

Parameters:
XLEN, 32, data width of every source and of the writeback result
NUM_SRC, 6, number of writeback sources (index order: 0 alu, 1 lu, 2 imm, 3 iadder, 4 csr, 5 pc+4)
SEL_W, 3, width of the select field; must satisfy 2**SEL_W >= NUM_SRC
LOAD_SEL, 1, select value whose data comes from the load unit and may arrive late
CNT_W, 64, width of the retire counter

Ports:
clk_in  input  1  core clock; all state updates on its rising edge
rst_in  input  1  synchronous, active-high reset
valid_in  input  1  an instruction is presented for writeback
ready_out  output  1  the stage can accept an instruction this cycle
wb_mux_sel_in  input  SEL_W  writeback source select
src_data_in  input  NUM_SRC*XLEN  flattened sources; source k is bits [k*XLEN +: XLEN]
rd_addr_in  input  5  destination register
rf_wr_en_in  input  1  the instruction writes rd
lu_valid_in  input  1  load-unit data on source LOAD_SEL is valid this cycle
stall_in  input  1  hold; accept nothing new
flush_in  input  1  kill the pending and presented instruction
rs2_in  input  XLEN  rs2 operand
imm_in  input  XLEN  immediate operand
alu_src_in  input  1  1 selects rs2, 0 selects imm
alu_2nd_src_out  output  XLEN  combinational: alu_src_in ? rs2_in : imm_in
wb_data_out  output  XLEN  registered writeback data
rd_addr_out  output  5  registered destination
rf_wr_en_out  output  1  register-file write strobe, one-cycle pulse
wb_valid_out  output  1  one-cycle pulse per retired instruction
instret_out  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_in=1 at a clock edge): state=IDLE; wb_data_out=0, rd_addr_out=0, rf_wr_en_out=0, wb_valid_out=0, instret_out=0. Reset aborts WAIT_LOAD and discards the pending instruction.
- Source select: a select value >= NUM_SRC selects source 0.
- ready_out = (state==IDLE) && !stall_in. It is combinational.
- Accept condition: valid_in && ready_out && !flush_in.
- IDLE state:
  - Accept with sel != LOAD_SEL, or with sel == LOAD_SEL and lu_valid_in=1: the next edge registers the selected source, rd and write enable, and pulses wb_valid_out. Latency is 1 cycle.
  - Accept with sel == LOAD_SEL and lu_valid_in=0: capture rd_addr_in and rf_wr_en_in internally, go to WAIT_LOAD, and emit no pulse.
- WAIT_LOAD state:
  - ready_out=0.
  - When lu_valid_in=1: the next edge registers source LOAD_SEL, pulses the outputs and returns to IDLE.
  - stall_in does not block load completion.
- Output pulses and holds:
  - rf_wr_en_out = captured rf_wr_en && (rd != 0), asserted only in a retire cycle.
  - wb_valid_out and rf_wr_en_out are high for exactly one cycle per instruction.
  - wb_data_out and rd_addr_out hold their last value until the next retire.
- Flush:
  - flush_in=1 in IDLE: nothing is accepted and the next-cycle pulses are 0.
  - flush_in=1 in WAIT_LOAD: return to IDLE with no pulse, even if lu_valid_in=1 in the same cycle (flush wins).
  - Reset has priority over flush.
- Counter: instret_out increments by 1 on every wb_valid_out pulse (in the same edge the pulse is registered). It wraps modulo 2**CNT_W.
- Stall in IDLE: no accept, pulses are 0 and the data registers hold.

Test Plan:
- Reset, then accept sel=0, src0=0x0000_1234, rd=5, wr=1 -> next cycle wb_data_out=0x1234, rd_addr_out=5, rf_wr_en_out=1 and wb_valid_out=1 for one cycle; instret_out=1.
- Sel=LOAD_SEL with lu_valid_in=0, then lu_valid_in=1 three cycles later with data 0xDEAD_BEEF -> ready_out=0 during the wait; one pulse with 0xDEADBEEF the cycle after lu_valid_in; instret_out=1.
- rd=0, wr=1, sel=2, imm=0x7 -> wb_valid_out=1, rf_wr_en_out=0, wb_data_out=7.
- In WAIT_LOAD, assert flush_in and lu_valid_in together -> no pulse, state returns to IDLE, instret_out unchanged; a following accept works normally.
- sel=7 with NUM_SRC=6 -> source 0 is written. Back-to-back accepts for 4 cycles -> 4 pulses and instret_out=4. stall_in=1 -> ready_out=0 and no pulses.
- alu_src_in=1/0 with rs2=0xA, imm=0xB -> alu_2nd_src_out=0xA / 0xB in the same cycle. rst_in asserted mid-WAIT_LOAD -> all outputs 0 next cycle.
